// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// fetch_queue
//
// Dual-issue instruction queue between fetch and decode. Fetch delivers one
// instruction pair per cycle together with the PC that follows the pair. The
// pair is split into two single-instruction slots of a circular array. Decode
// sees the two oldest instructions, each with its own PC and valid flag, and
// consumes 0, 1 or 2 of them per cycle. A redirect (flush) empties the queue.
//
// Parameters
//   DEPTH    capacity in instruction pairs (2*DEPTH slots), power of two, >= 2
//   D_WIDTH  instruction and PC width
//
// Ports
//   clk             in   clock, all state updates on the rising edge
//   rst_n           in   synchronous active-low reset
//   i_Valid         in   fetch pair valid
//   i_PC            in   address after the pair (older instr at i_PC-8)
//   i_Instruction1  in   older instruction of the pair
//   i_Instruction2  in   younger instruction of the pair
//   i_Flush         in   pipeline redirect, discards everything
//   i_Consume       in   instructions taken by decode (3 behaves as 2)
//   o_StallF        out  fetch must hold its PC (fewer than 2 free slots)
//   o_Valid1/2      out  head / head+1 slot holds an instruction
//   o_Instruction1/2 out head / head+1 instruction (stale when not valid)
//   o_PC1/2         out  address of head / head+1 instruction
//   o_Count         out  occupied slots
//   o_StallCycles   out  (FETCHQ_PERF_EN only) saturating count of cycles in
//                        which fetch offered a pair while stalled
//
// Build option: define FETCHQ_PERF_EN to add the o_StallCycles counter.
//------------------------------------------------------------------------------
module fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int D_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              i_Valid,
   input  logic [D_WIDTH-1:0]                i_PC,
   input  logic [D_WIDTH-1:0]                i_Instruction1,
   input  logic [D_WIDTH-1:0]                i_Instruction2,
   input  logic                              i_Flush,
   input  logic [1:0]                        i_Consume,
   output logic                              o_StallF,
   output logic                              o_Valid1,
   output logic                              o_Valid2,
   output logic [D_WIDTH-1:0]                o_Instruction1,
   output logic [D_WIDTH-1:0]                o_Instruction2,
   output logic [D_WIDTH-1:0]                o_PC1,
   output logic [D_WIDTH-1:0]                o_PC2,
`ifdef FETCHQ_PERF_EN
   output logic [15:0]                       o_StallCycles,
`endif
   output logic [$clog2(2*DEPTH):0]          o_Count
);

   localparam int SLOTS = 2 * DEPTH;
   localparam int PW    = $clog2(SLOTS);
   localparam int CW    = PW + 1;

   typedef struct packed {
      logic [D_WIDTH-1:0] instr;
      logic [D_WIDTH-1:0] pc;
   } slot_t;

   slot_t            slot_q [SLOTS];
   logic [PW-1:0]    wp_q, wp_d;
   logic [PW-1:0]    rp_q, rp_d;
   logic [CW-1:0]    count_q, count_d;

   logic             stall;
   logic             wr;
   logic [1:0]       consume_eff;
   logic [CW-1:0]    rd;
   logic [PW-1:0]    wp_plus1;
   logic [PW-1:0]    rp_plus1;

   // Stall looks at registered occupancy only: a same-cycle read never frees
   // room for the same-cycle write, which keeps o_StallF off the decode path.
   assign stall    = (count_q > CW'(SLOTS - 2));
   assign wr       = i_Valid & ~stall & ~i_Flush;
   assign wp_plus1 = wp_q + PW'(1);
   assign rp_plus1 = rp_q + PW'(1);

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      consume_eff = (i_Consume == 2'd3) ? 2'd2 : i_Consume;
      // Over-consume is clipped to what is actually held.
      rd          = (CW'(consume_eff) > count_q) ? count_q : CW'(consume_eff);
      wp_d        = wp_q;
      rp_d        = rp_q;
      count_d     = count_q;
      if (i_Flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (wr) begin
            wp_d = wp_q + PW'(2);
         end
         rp_d    = rp_q + PW'(rd);
         count_d = count_q + (wr ? CW'(2) : CW'(0)) - rd;
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         // NOTE: the slot array is cleared on reset because the outputs must
         // read 0 afterwards; this costs a reset on every slot flop.
         for (int i = 0; i < SLOTS; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         if (wr) begin
            slot_q[wp_q]     <= '{instr: i_Instruction1, pc: i_PC - D_WIDTH'(8)};
            slot_q[wp_plus1] <= '{instr: i_Instruction2, pc: i_PC - D_WIDTH'(4)};
         end
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   assign o_StallF       = stall;
   assign o_Valid1       = (count_q >= CW'(1));
   assign o_Valid2       = (count_q >= CW'(2));
   assign o_Instruction1 = slot_q[rp_q].instr;
   assign o_PC1          = slot_q[rp_q].pc;
   assign o_Instruction2 = slot_q[rp_plus1].instr;
   assign o_PC2          = slot_q[rp_plus1].pc;
   assign o_Count        = count_q;

`ifdef FETCHQ_PERF_EN
   logic [15:0] stall_cycles_q;

   // Counts cycles where fetch had a pair ready but was held off.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
      end else if (i_Valid && stall && !i_Flush && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_q <= stall_cycles_q + 16'd1;
      end
   end

   assign o_StallCycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int SLOTS = 2 * DEPTH;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_Valid;
   logic [DW-1:0] i_PC, i_Instruction1, i_Instruction2;
   logic          i_Flush;
   logic [1:0]    i_Consume;
   logic          o_StallF, o_Valid1, o_Valid2;
   logic [DW-1:0] o_Instruction1, o_Instruction2, o_PC1, o_PC2;
   logic [$clog2(SLOTS):0] o_Count;
`ifdef FETCHQ_PERF_EN
   logic [15:0]   o_StallCycles;
   int            m_stall_cycles;
`endif

   fetch_queue #(.DEPTH(DEPTH), .D_WIDTH(DW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_Valid        (i_Valid),
      .i_PC           (i_PC),
      .i_Instruction1 (i_Instruction1),
      .i_Instruction2 (i_Instruction2),
      .i_Flush        (i_Flush),
      .i_Consume      (i_Consume),
      .o_StallF       (o_StallF),
      .o_Valid1       (o_Valid1),
      .o_Valid2       (o_Valid2),
      .o_Instruction1 (o_Instruction1),
      .o_Instruction2 (o_Instruction2),
      .o_PC1          (o_PC1),
      .o_PC2          (o_PC2),
`ifdef FETCHQ_PERF_EN
      .o_StallCycles  (o_StallCycles),
`endif
      .o_Count        (o_Count)
   );

   always #5 clk = ~clk;

   // Reference model: program-order list of instructions held by the queue.
   typedef struct {
      logic [DW-1:0] ins;
      logic [DW-1:0] pc;
   } ent_t;
   ent_t mq[$];

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] next_pc = 32'h0000_1008;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int n;
      n = mq.size();
      check("count",  DW'(o_Count),  DW'(n));
      check("valid1", DW'(o_Valid1), DW'(n >= 1));
      check("valid2", DW'(o_Valid2), DW'(n >= 2));
      check("stallF", DW'(o_StallF), DW'(n >= SLOTS - 1));
      if (n >= 1) begin
         check("instr1", o_Instruction1, mq[0].ins);
         check("pc1",    o_PC1,          mq[0].pc);
      end
      if (n >= 2) begin
         check("instr2", o_Instruction2, mq[1].ins);
         check("pc2",    o_PC2,          mq[1].pc);
      end
`ifdef FETCHQ_PERF_EN
      check("stall_cycles", DW'(o_StallCycles), DW'(m_stall_cycles));
`endif
   endtask

   // One clock: drive inputs, advance the model by the queue's rules, compare.
   task automatic step(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic fl, input logic [1:0] cons);
      bit full;
      int take;
      i_Valid = v; i_PC = pc; i_Instruction1 = a; i_Instruction2 = b;
      i_Flush = fl; i_Consume = cons;
      full = (mq.size() > SLOTS - 2);
`ifdef FETCHQ_PERF_EN
      if (v && full && !fl && m_stall_cycles < 16'hFFFF) m_stall_cycles++;
`endif
      if (fl) begin
         mq.delete();
      end else begin
         take = (cons == 2'd3) ? 2 : int'(cons);
         if (take > mq.size()) take = mq.size();
         repeat (take) void'(mq.pop_front());
         if (v && !full) begin
            mq.push_back('{ins: a, pc: pc - 32'd8});
            mq.push_back('{ins: b, pc: pc - 32'd4});
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic write_pair(input logic [1:0] cons);
      step(1'b1, next_pc, $urandom, $urandom, 1'b0, cons);
      next_pc = next_pc + 32'd8;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_Valid = 1'b1; i_PC = 32'h40; i_Instruction1 = 32'hDEAD; i_Instruction2 = 32'hBEEF;
      i_Flush = 1'b0; i_Consume = 2'd1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mq.delete();
`ifdef FETCHQ_PERF_EN
      m_stall_cycles = 0;
      check("rst_stall_cycles", DW'(o_StallCycles), 32'd0);
`endif
      check("rst_count",  DW'(o_Count),  32'd0);
      check("rst_valid1", DW'(o_Valid1), 32'd0);
      check("rst_valid2", DW'(o_Valid2), 32'd0);
      check("rst_stallF", DW'(o_StallF), 32'd0);
      check("rst_instr1", o_Instruction1, 32'd0);
      check("rst_instr2", o_Instruction2, 32'd0);
      check("rst_pc1",    o_PC1, 32'd0);
      check("rst_pc2",    o_PC2, 32'd0);
   endtask

   initial begin
      rst_n = 1'b1;
      i_Valid = 1'b0; i_PC = '0; i_Instruction1 = '0; i_Instruction2 = '0;
      i_Flush = 1'b0; i_Consume = '0;
`ifdef FETCHQ_PERF_EN
      m_stall_cycles = 0;
`endif
      #2;
      do_reset();

      // Basic fill
      step(1'b1, 32'h108, 32'hA1, 32'hA2, 1'b0, 2'd0);
      check("fill_pc1",    o_PC1, 32'h100);
      check("fill_pc2",    o_PC2, 32'h104);
      check("fill_instr1", o_Instruction1, 32'hA1);
      check("fill_count",  DW'(o_Count), 32'd2);

      // Full / stall: three more pairs, then a dropped fifth
      write_pair(2'd0);
      write_pair(2'd0);
      check("three_pairs_stall", DW'(o_StallF), 32'd0);
      check("three_pairs_count", DW'(o_Count), 32'd6);
      write_pair(2'd0);
      check("four_pairs_stall", DW'(o_StallF), 32'd1);
      check("four_pairs_count", DW'(o_Count), 32'd8);
      write_pair(2'd0);
      check("dropped_count", DW'(o_Count), 32'd8);

      // Odd consume across the slot wrap
      do_reset();
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) write_pair(2'd1);
         else step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1);
         if (o_Valid2 && mq.size() >= 2)
            check("wrap_pc_order", o_PC2, mq[1].pc);
      end

      // Over-consume
      do_reset();
      write_pair(2'd0);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2);
      check("overconsume_count",  DW'(o_Count),  32'd0);
      check("overconsume_valid1", DW'(o_Valid1), 32'd0);
      write_pair(2'd3);

      // Flush with simultaneous write and consume
      write_pair(2'd0);
      step(1'b1, 32'h2008, 32'h77, 32'h78, 1'b1, 2'd2);
      check("flush_count", DW'(o_Count), 32'd0);
      step(1'b1, 32'h3008, 32'h55, 32'h56, 1'b0, 2'd0);
      check("post_flush_pc1", o_PC1, 32'h3000);
      check("post_flush_instr1", o_Instruction1, 32'h55);

      // Reset mid-operation with count=5
      do_reset();
      write_pair(2'd0);
      write_pair(2'd0);
      write_pair(2'd0);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1);
      check("pre_reset_count", DW'(o_Count), 32'd5);
      do_reset();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, next_pc, $urandom, $urandom,
              $urandom_range(0, 31) == 0, 2'($urandom_range(0, 3)));
         next_pc = next_pc + 32'd8;
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
